osc_read_scheduler: RTL

- Time-multiplexes the single read port of the oscillator wave BRAM among NUM_OSCILLATORS playback voices using a fixed round-robin slot schedule.
- Tracks in-flight reads through the BRAM pipeline latency and steers each returned sample into its voice's output register.
- Gates voices that are off or whose index exceeds the loaded wave width.
- Arbitrates the BRAM against the wave reload path: drains in-flight reads, grants the reload, and resumes playback when the reload completes.

---
 rtl/osc_read_scheduler_if.sv | 33 +++
 rtl/osc_read_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/osc_read_scheduler_if.sv
// Bus bundle between the oscillator read scheduler, its voices, the wave BRAM
// read port and the wave reload path.
interface osc_read_scheduler_if #(
    parameter int unsigned NUM_OSCILLATORS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned WW_WIDTH        = 18
);
    logic [NUM_OSCILLATORS-1:0]                   osc_is_on_in;
    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     osc_index_in;
    logic [WW_WIDTH-1:0]                          wave_width_in;
    logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_data_out;
    logic [NUM_OSCILLATORS-1:0]                   osc_valid_out;
    logic [WW_WIDTH-1:0]                          bram_addr_out;
    logic                                         bram_en_out;
    logic [SAMPLE_WIDTH-1:0]                      bram_data_in;
    logic                                         reload_req_in;
    logic                                         reload_gnt_out;
    logic                                         reload_done_in;

    // Environment side: voices, BRAM and loader.
    modport master (
        output osc_is_on_in, osc_index_in, wave_width_in,
        output bram_data_in, reload_req_in, reload_done_in,
        input  osc_data_out, osc_valid_out, bram_addr_out, bram_en_out, reload_gnt_out
    );

    // Scheduler side.
    modport slave (
        input  osc_is_on_in, osc_index_in, wave_width_in,
        input  bram_data_in, reload_req_in, reload_done_in,
        output osc_data_out, osc_valid_out, bram_addr_out, bram_en_out, reload_gnt_out
    );
endinterface

// File: rtl/osc_read_scheduler.sv
// Round-robin scheduler sharing one wave BRAM read port among playback voices,
// with drain/grant handover of the BRAM to the wave reload path.
module osc_read_scheduler #(
    parameter int unsigned NUM_OSCILLATORS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned WW_WIDTH        = 18,
    parameter int unsigned BRAM_LATENCY    = 2
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    osc_read_scheduler_if.slave bus
);
    localparam int unsigned SLOT_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam int unsigned DEPTH  = BRAM_LATENCY + 1;
    localparam int unsigned CNT_W  = $clog2(BRAM_LATENCY + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_OSCILLATORS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(BRAM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
        logic              zero;
    } tag_t;

    state_t                                       state_q, state_d;
    logic [SLOT_W-1:0]                            slot_q, slot_d;
    logic [CNT_W-1:0]                             drain_cnt_q, drain_cnt_d;
    tag_t [DEPTH-1:0]                             tag_q, tag_d;
    logic [WW_WIDTH-1:0]                          addr_q, addr_d;
    logic                                         en_q, en_d;
    logic                                         gnt_q, gnt_d;
    logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] data_q, data_d;
    logic [NUM_OSCILLATORS-1:0]                   valid_q, valid_d;

    logic [WW_WIDTH-1:0] cur_idx_c;
    logic                cur_zero_c;
    tag_t                ret_tag_c;

    // Slot currently up for issue and whether it must be forced to silence.
    assign cur_idx_c  = bus.osc_index_in[slot_q];
    assign cur_zero_c = !bus.osc_is_on_in[slot_q] || (cur_idx_c >= bus.wave_width_in);
    assign ret_tag_c  = tag_q[DEPTH-1];

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        drain_cnt_d = drain_cnt_q;
        addr_d      = addr_q;
        en_d        = 1'b0;
        gnt_d       = gnt_q;
        data_d      = data_q;
        valid_d     = '0;
        tag_d       = '0;

        // Tags advance every cycle in every state so in-flight reads always retire.
        for (int unsigned i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (ret_tag_c.valid) begin
            valid_d[ret_tag_c.slot] = 1'b1;
            data_d[ret_tag_c.slot]  = ret_tag_c.zero ? '0 : bus.bram_data_in;
        end

        unique case (state_q)
            ST_RUN: begin
                if (bus.reload_req_in) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    addr_d         = cur_idx_c;
                    en_d           = !cur_zero_c;
                    tag_d[0].valid = 1'b1;
                    tag_d[0].slot  = slot_q;
                    tag_d[0].zero  = cur_zero_c;
                    slot_d         = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
                end
            end
            ST_DRAIN: begin
                // A withdrawn request resumes playback at the frozen slot.
                if (!bus.reload_req_in) begin
                    state_d = ST_RUN;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HOLD;
                    gnt_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.reload_done_in) begin
                    state_d = ST_RUN;
                    gnt_d   = 1'b0;
                    slot_d  = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                gnt_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_RUN;
            slot_q      <= '0;
            drain_cnt_q <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            gnt_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            drain_cnt_q <= drain_cnt_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.osc_data_out   = data_q;
    assign bus.osc_valid_out  = valid_q;
    assign bus.bram_addr_out  = addr_q;
    assign bus.bram_en_out    = en_q;
    assign bus.reload_gnt_out = gnt_q;

endmodule
